// File: rtl/proc_control_fsm.sv
// Multicycle control unit for the 16-bit processor: fetch/decode/execute sequencing of PC, IR, D-mem, RF and ALU.
// Optional: define PROC_ILLEGAL_TRAP_EN to send opcodes 7..F to Halt instead of NoOp.
module proc_control_fsm #(
  parameter int WIDTH       = 16,
  parameter int DADDR_WIDTH = 8,
  parameter int RADDR_WIDTH = 4,
  parameter int STATE_WIDTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [WIDTH-1:0]       IR,
  input  logic                   ALU_Zero,
  output logic                   PC_Clr,
  output logic                   PC_Up,
  output logic                   PC_Ld,
  output logic [7:0]             PC_Offset,
  output logic                   IR_Ld,
  output logic [DADDR_WIDTH-1:0] D_Addr,
  output logic                   D_Wr,
  output logic                   RF_s,
  output logic [RADDR_WIDTH-1:0] RF_W_addr,
  output logic                   RF_W_en,
  output logic [RADDR_WIDTH-1:0] RF_Ra_addr,
  output logic [RADDR_WIDTH-1:0] RF_Rb_addr,
  output logic [1:0]             ALU_s,
  output logic [STATE_WIDTH-1:0] State,
  output logic [STATE_WIDTH-1:0] NextState
);

  localparam logic [STATE_WIDTH-1:0] S_INIT    = STATE_WIDTH'(8'h00);
  localparam logic [STATE_WIDTH-1:0] S_FETCH   = STATE_WIDTH'(8'h01);
  localparam logic [STATE_WIDTH-1:0] S_DECODE  = STATE_WIDTH'(8'h02);
  localparam logic [STATE_WIDTH-1:0] S_NOOP    = STATE_WIDTH'(8'h03);
  localparam logic [STATE_WIDTH-1:0] S_LOADA   = STATE_WIDTH'(8'h04);
  localparam logic [STATE_WIDTH-1:0] S_LOADB   = STATE_WIDTH'(8'h05);
  localparam logic [STATE_WIDTH-1:0] S_STORE   = STATE_WIDTH'(8'h06);
  localparam logic [STATE_WIDTH-1:0] S_ADD     = STATE_WIDTH'(8'h07);
  localparam logic [STATE_WIDTH-1:0] S_SUB     = STATE_WIDTH'(8'h08);
  localparam logic [STATE_WIDTH-1:0] S_HALT    = STATE_WIDTH'(8'h09);
  localparam logic [STATE_WIDTH-1:0] S_JZTEST  = STATE_WIDTH'(8'h0A);
  localparam logic [STATE_WIDTH-1:0] S_JZJUMP  = STATE_WIDTH'(8'h0B);

  localparam logic [1:0] ALU_PASS_A = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;

  logic [STATE_WIDTH-1:0] r_state;
  logic [STATE_WIDTH-1:0] w_next;
  logic [3:0]             w_opcode;
  logic [DADDR_WIDTH-1:0] w_mem_addr;
  logic [RADDR_WIDTH-1:0] w_fld_hi;
  logic [RADDR_WIDTH-1:0] w_fld_mid;
  logic [RADDR_WIDTH-1:0] w_fld_lo;
  logic [STATE_WIDTH-1:0] w_illegal_target;

  assign w_opcode   = IR[15:12];
  assign w_mem_addr = DADDR_WIDTH'(IR[11:4]);
  assign w_fld_hi   = RADDR_WIDTH'(IR[11:8]);
  assign w_fld_mid  = RADDR_WIDTH'(IR[7:4]);
  assign w_fld_lo   = RADDR_WIDTH'(IR[3:0]);

`ifdef PROC_ILLEGAL_TRAP_EN
  assign w_illegal_target = S_HALT;
`else
  assign w_illegal_target = S_NOOP;
`endif

  // Async reset forces Init at once, so every strobe decoded below drops in the same instant.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_INIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!Reset_n) begin
      w_next = S_FETCH;
    end else begin
      case (r_state)
        S_INIT:   w_next = S_FETCH;
        S_FETCH:  w_next = S_DECODE;
        S_DECODE: begin
          case (w_opcode)
            4'h0:    w_next = S_NOOP;
            4'h1:    w_next = S_STORE;
            4'h2:    w_next = S_LOADA;
            4'h3:    w_next = S_ADD;
            4'h4:    w_next = S_SUB;
            4'h5:    w_next = S_HALT;
            4'h6:    w_next = S_JZTEST;
            default: w_next = w_illegal_target;
          endcase
        end
        S_LOADA:  w_next = S_LOADB;
        S_JZTEST: w_next = ALU_Zero ? S_JZJUMP : S_FETCH;
        S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB, S_JZJUMP: w_next = S_FETCH;
        S_HALT:   w_next = S_HALT;
        default:  w_next = S_INIT;
      endcase
    end
  end

  always_comb begin
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    PC_Ld      = 1'b0;
    PC_Offset  = 8'h00;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s      = ALU_PASS_A;
    case (r_state)
      S_INIT: PC_Clr = 1'b1;
      S_FETCH: begin
        IR_Ld = 1'b1;
        PC_Up = 1'b1;
      end
      S_STORE: begin
        D_Addr     = w_mem_addr;
        RF_Ra_addr = w_fld_lo;
        ALU_s      = ALU_PASS_A;
        D_Wr       = 1'b1;
      end
      // LoadA only lets the D-mem read settle; the write happens in LoadB.
      S_LOADA, S_LOADB: begin
        D_Addr    = w_mem_addr;
        RF_s      = 1'b1;
        RF_W_addr = w_fld_lo;
        RF_W_en   = (r_state == S_LOADB);
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = w_fld_hi;
        RF_Rb_addr = w_fld_mid;
        RF_W_addr  = w_fld_lo;
        ALU_s      = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_en    = 1'b1;
      end
      S_JZTEST: begin
        RF_Ra_addr = w_fld_hi;
        ALU_s      = ALU_PASS_A;
      end
      S_JZJUMP: begin
        PC_Ld     = 1'b1;
        PC_Offset = IR[7:0];
      end
      default: ;
    endcase
  end

  assign State     = r_state;
  assign NextState = w_next;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm; honours PROC_ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_proc_control_fsm;

  logic       Clock;
  logic       Reset_n;
  logic [15:0] IR;
  logic       ALU_Zero;
  logic       PC_Clr, PC_Up, PC_Ld, IR_Ld, D_Wr, RF_s, RF_W_en;
  logic [7:0] PC_Offset, D_Addr, State, NextState;
  logic [3:0] RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [1:0] ALU_s;
  logic [5:0] strb;

  int checks = 0;
  int errors = 0;

  proc_control_fsm dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .ALU_Zero(ALU_Zero),
    .PC_Clr(PC_Clr), .PC_Up(PC_Up), .PC_Ld(PC_Ld), .PC_Offset(PC_Offset),
    .IR_Ld(IR_Ld), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .ALU_s(ALU_s), .State(State), .NextState(NextState)
  );

  // strobe order: PC_Clr PC_Up PC_Ld IR_Ld D_Wr RF_W_en
  assign strb = {PC_Clr, PC_Up, PC_Ld, IR_Ld, D_Wr, RF_W_en};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; IR = 16'h0000; ALU_Zero = 1'b0;
    step(); step();
    checks++; if (State !== 8'h00) begin errors++; $display("FAIL reset_state got %h exp 00", State); end
    checks++; if (strb !== 6'b100000) begin errors++; $display("FAIL reset_strobes got %b exp 100000", strb); end
    checks++; if (NextState !== 8'h01) begin errors++; $display("FAIL reset_next got %h exp 01", NextState); end
    Reset_n = 1'b1;
    #1;
    checks++; if (State !== 8'h00 || PC_Clr !== 1'b1) begin errors++; $display("FAIL init_hold got %h/%b exp 00/1", State, PC_Clr); end
    step();
    checks++; if (State !== 8'h01) begin errors++; $display("FAIL first_fetch got %h exp 01", State); end
    checks++; if (strb !== 6'b010100) begin errors++; $display("FAIL fetch_strobes got %b exp 010100", strb); end
    checks++; if (NextState !== 8'h02) begin errors++; $display("FAIL fetch_next got %h exp 02", NextState); end
  endtask

  task automatic test_add();
    IR = 16'h3123;
    step();
    checks++; if (State !== 8'h02 || NextState !== 8'h07) begin errors++; $display("FAIL add_decode got %h->%h exp 02->07", State, NextState); end
    checks++; if (strb !== 6'b000000) begin errors++; $display("FAIL decode_strobes got %b exp 000000", strb); end
    step();
    checks++; if (State !== 8'h07) begin errors++; $display("FAIL add_state got %h exp 07", State); end
    checks++; if ({RF_Ra_addr, RF_Rb_addr, RF_W_addr, ALU_s, RF_s} !== {4'h1, 4'h2, 4'h3, 2'b01, 1'b0}) begin
      errors++; $display("FAIL add_fields got ra%h rb%h w%h alu%b s%b exp ra1 rb2 w3 alu01 s0", RF_Ra_addr, RF_Rb_addr, RF_W_addr, ALU_s, RF_s); end
    checks++; if (strb !== 6'b000001) begin errors++; $display("FAIL add_strobes got %b exp 000001", strb); end
    step();
    checks++; if (State !== 8'h01 || RF_W_en !== 1'b0) begin errors++; $display("FAIL add_done got %h/%b exp 01/0", State, RF_W_en); end
  endtask

  task automatic test_sub();
    IR = 16'h49C5;
    step(); step();
    checks++; if (State !== 8'h08 || ALU_s !== 2'b10 || RF_W_en !== 1'b1) begin errors++; $display("FAIL sub_state got %h alu%b we%b exp 08 10 1", State, ALU_s, RF_W_en); end
    checks++; if ({RF_Ra_addr, RF_Rb_addr, RF_W_addr} !== 12'h9C5) begin errors++; $display("FAIL sub_fields got %h%h%h exp 9c5", RF_Ra_addr, RF_Rb_addr, RF_W_addr); end
    step();
    checks++; if (State !== 8'h01) begin errors++; $display("FAIL sub_done got %h exp 01", State); end
  endtask

  task automatic test_load();
    IR = 16'h2A57;
    step();
    checks++; if (NextState !== 8'h04) begin errors++; $display("FAIL load_decode got %h exp 04", NextState); end
    step();
    checks++; if (State !== 8'h04 || D_Addr !== 8'hA5 || RF_W_en !== 1'b0) begin errors++; $display("FAIL loada got %h a%h we%b exp 04 a5 0", State, D_Addr, RF_W_en); end
    checks++; if (RF_s !== 1'b1 || RF_W_addr !== 4'h7) begin errors++; $display("FAIL loada_fields got s%b w%h exp s1 w7", RF_s, RF_W_addr); end
    step();
    checks++; if (State !== 8'h05 || strb !== 6'b000001 || RF_s !== 1'b1 || RF_W_addr !== 4'h7 || D_Addr !== 8'hA5) begin
      errors++; $display("FAIL loadb got %h %b s%b w%h a%h exp 05 000001 s1 w7 a5", State, strb, RF_s, RF_W_addr, D_Addr); end
    step();
    checks++; if (State !== 8'h01) begin errors++; $display("FAIL load_done got %h exp 01", State); end
  endtask

  task automatic test_store();
    IR = 16'h1A53;
    step(); step();
    checks++; if (State !== 8'h06 || strb !== 6'b000010) begin errors++; $display("FAIL store got %h %b exp 06 000010", State, strb); end
    checks++; if (D_Addr !== 8'hA5 || RF_Ra_addr !== 4'h3 || ALU_s !== 2'b00) begin errors++; $display("FAIL store_fields got a%h ra%h alu%b exp a5 3 00", D_Addr, RF_Ra_addr, ALU_s); end
    step();
    checks++; if (State !== 8'h01) begin errors++; $display("FAIL store_done got %h exp 01", State); end
  endtask

  task automatic test_jz();
    IR = 16'h64FE; ALU_Zero = 1'b1;
    step(); step();
    checks++; if (State !== 8'h0A || RF_Ra_addr !== 4'h4 || ALU_s !== 2'b00 || NextState !== 8'h0B) begin
      errors++; $display("FAIL jz_test got %h ra%h alu%b n%h exp 0a 4 00 0b", State, RF_Ra_addr, ALU_s, NextState); end
    checks++; if (strb !== 6'b000000) begin errors++; $display("FAIL jz_test_strobes got %b exp 000000", strb); end
    step();
    checks++; if (State !== 8'h0B || strb !== 6'b001000 || PC_Offset !== 8'hFE) begin errors++; $display("FAIL jz_jump got %h %b off%h exp 0b 001000 fe", State, strb, PC_Offset); end
    step();
    checks++; if (State !== 8'h01 || PC_Ld !== 1'b0) begin errors++; $display("FAIL jz_taken_done got %h/%b exp 01/0", State, PC_Ld); end
    ALU_Zero = 1'b0;
    step(); step();
    checks++; if (State !== 8'h0A || NextState !== 8'h01) begin errors++; $display("FAIL jz_not_taken got %h->%h exp 0a->01", State, NextState); end
    step();
    checks++; if (State !== 8'h01) begin errors++; $display("FAIL jz_nt_done got %h exp 01", State); end
  endtask

  task automatic test_noop();
    IR = 16'h0000;
    step();
    checks++; if (NextState !== 8'h03) begin errors++; $display("FAIL noop_decode got %h exp 03", NextState); end
    step();
    checks++; if (State !== 8'h03 || strb !== 6'b000000) begin errors++; $display("FAIL noop got %h %b exp 03 000000", State, strb); end
    step();
    checks++; if (State !== 8'h01) begin errors++; $display("FAIL noop_done got %h exp 01", State); end
  endtask

  task automatic test_reset_mid_load();
    IR = 16'h2A57;
    step(); step();
    @(posedge Clock); #2 Reset_n = 1'b0; #1;
    checks++; if (State !== 8'h00 || strb !== 6'b100000) begin errors++; $display("FAIL mid_reset got %h %b exp 00 100000", State, strb); end
    step(); Reset_n = 1'b1;
    step();
    checks++; if (State !== 8'h01) begin errors++; $display("FAIL mid_reset_fetch got %h exp 01", State); end
  endtask

  task automatic test_halt();
    int bad;
    IR = 16'h5000;
    step(); step();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (State !== 8'h09 || strb !== 6'b000000 || NextState !== 8'h09) bad++;
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL halt_hold got %0d bad cycles exp 0", bad); end
    @(posedge Clock); #3 Reset_n = 1'b0; #1;
    checks++; if (State !== 8'h00 || PC_Clr !== 1'b1) begin errors++; $display("FAIL halt_reset got %h/%b exp 00/1", State, PC_Clr); end
    step(); Reset_n = 1'b1;
    step();
    checks++; if (State !== 8'h01) begin errors++; $display("FAIL halt_restart got %h exp 01", State); end
  endtask

  task automatic test_illegal();
    IR = 16'hF000;
    step();
`ifdef PROC_ILLEGAL_TRAP_EN
    checks++; if (NextState !== 8'h09) begin errors++; $display("FAIL illegal_decode got %h exp 09", NextState); end
    step(); step();
    checks++; if (State !== 8'h09) begin errors++; $display("FAIL illegal_trap got %h exp 09", State); end
`else
    checks++; if (NextState !== 8'h03) begin errors++; $display("FAIL illegal_decode got %h exp 03", NextState); end
    step();
    checks++; if (State !== 8'h03) begin errors++; $display("FAIL illegal_noop got %h exp 03", State); end
    step();
    checks++; if (State !== 8'h01) begin errors++; $display("FAIL illegal_done got %h exp 01", State); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_load();
    test_store();
    test_jz();
    test_noop();
    test_reset_mid_load();
    test_halt();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
